fft_stage_sequencer: RTL and testbench

//  Sequences an in-place radix-2 DIT FFT over a dual-port sample BRAM and a twiddle ROM.
//  Per stage: issues one butterfly read pair plus twiddle address per cycle.

---
 rtl/fft_stage_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Address sequencer for an in-place radix-2 decimation-in-time FFT. Each stage
// issues one butterfly read pair (plus its twiddle address) per cycle. The
// same address pair is replayed as a write-back once the butterfly pipeline
// has produced the result. Between stages the sequencer waits for that
// pipeline to empty, so a stage never reads a location that the previous
// stage has not yet written.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous reset, active-high
//   start_i         in   start request, sampled only while idle
//   abort_i         in   synchronous abort: back to idle, pending writes dropped
//   busy_o          out  high while running, draining or signalling done
//   done_o          out  one-cycle pulse after the last write of the last stage
//   stage_o         out  current stage (0 when no read is issued)
//   rd_en_o         out  butterfly read strobe, also the twiddle ROM enable
//   rd_addr_a_o     out  upper butterfly input address
//   rd_addr_b_o     out  lower butterfly input address
//   twiddle_addr_o  out  twiddle ROM address
//   bf_ce_o         out  butterfly clock enable (read or any result in flight)
//   wr_en_o         out  write-back strobe for both BRAM ports
//   wr_addr_a_o     out  write address for result A
//   wr_addr_b_o     out  write address for result B
module fft_stage_sequencer #(
    parameter int  N          = 1024,
    parameter int  BF_LATENCY = 4,
    localparam int LOG2N      = $clog2(N),
    localparam int SW         = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [SW-1:0]    stage_o,
    output logic             rd_en_o,
    output logic [LOG2N-1:0] rd_addr_a_o,
    output logic [LOG2N-1:0] rd_addr_b_o,
    output logic [LOG2N-2:0] twiddle_addr_o,
    output logic             bf_ce_o,
    output logic             wr_en_o,
    output logic [LOG2N-1:0] wr_addr_a_o,
    output logic [LOG2N-1:0] wr_addr_b_o
);

    // The butterfly counter and the twiddle address are both LOG2N-1 bits wide.
    localparam int KW = LOG2N - 1;
    localparam int CW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

    localparam logic [KW-1:0] K_LAST   = '1;
    localparam logic [SW-1:0] S_LAST   = SW'(LOG2N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BF_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             rd_en_q, rd_en_d;
    logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [KW-1:0]    twiddle_q, twiddle_d;
    logic             bf_ce_q, bf_ce_d;

    // Write-back delay line; index BF_LATENCY-1 drives the write port.
    logic [BF_LATENCY-1:0] vld_q, vld_d;
    logic [LOG2N-1:0]      pa_q [BF_LATENCY];
    logic [LOG2N-1:0]      pa_d [BF_LATENCY];
    logic [LOG2N-1:0]      pb_q [BF_LATENCY];
    logic [LOG2N-1:0]      pb_d [BF_LATENCY];

    // Address arithmetic intermediates.
    logic [KW-1:0]    half_k, pos_k;
    logic [LOG2N-1:0] half, grp;

    // Next-state sequencing for the state machine and its counters.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (abort_i) begin
            state_d = IDLE;
            s_d     = '0;
            k_d     = '0;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from the next state, so they line up with the
    // state the machine is in during that cycle.
    always_comb begin
        // half is computed modulo 2^KW: in the last stage it wraps to 0, so
        // half_k - 1 becomes all ones and pos_k is simply k.
        half_k = KW'(1) << s_d;
        pos_k  = k_d & (half_k - KW'(1));
        half   = LOG2N'(1) << s_d;
        grp    = {1'b0, k_d} >> s_d;

        rd_en_d     = (state_d == RUN);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        stage_d     = '0;
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        twiddle_d   = '0;

        if (rd_en_d) begin
            stage_d     = s_d;
            // Insert a zero bit at position s to get the upper butterfly leg.
            rd_addr_a_d = (grp << (int'(s_d) + 1)) | {1'b0, pos_k};
            rd_addr_b_d = rd_addr_a_d + half;
            twiddle_d   = pos_k << (LOG2N - 1 - int'(s_d));
        end
    end

    // Write-back delay line: shift the issued read pair forward each cycle.
    always_comb begin
        vld_d[0] = rd_en_q;
        pa_d[0]  = rd_addr_a_q;
        pb_d[0]  = rd_addr_b_q;
        for (int i = 1; i < BF_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            pa_d[i]  = pa_q[i-1];
            pb_d[i]  = pb_q[i-1];
        end
        if (abort_i) begin
            vld_d = '0;
            for (int i = 0; i < BF_LATENCY; i++) begin
                pa_d[i] = '0;
                pb_d[i] = '0;
            end
        end
        bf_ce_d = rd_en_d | (|vld_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            twiddle_q   <= '0;
            bf_ce_q     <= 1'b0;
            vld_q       <= '0;
            // NOTE: the delay line is a handful of flops rather than a RAM, so
            // it is reset in full; the write address outputs then start at 0.
            for (int i = 0; i < BF_LATENCY; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_q     <= stage_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            twiddle_q   <= twiddle_d;
            bf_ce_q     <= bf_ce_d;
            vld_q       <= vld_d;
            for (int i = 0; i < BF_LATENCY; i++) begin
                pa_q[i] <= pa_d[i];
                pb_q[i] <= pb_d[i];
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign stage_o        = stage_q;
    assign rd_en_o        = rd_en_q;
    assign rd_addr_a_o    = rd_addr_a_q;
    assign rd_addr_b_o    = rd_addr_b_q;
    assign twiddle_addr_o = twiddle_q;
    assign bf_ce_o        = bf_ce_q;
    assign wr_en_o        = vld_q[BF_LATENCY-1];
    assign wr_addr_a_o    = pa_q[BF_LATENCY-1];
    assign wr_addr_b_o    = pb_q[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer
// Drives two sequencer instances (N=8/L=2 and N=1024/L=4) and compares every
// output, every cycle, against a cycle-indexed reference model. The model
// computes the expected outputs from the stage/butterfly timetable with
// plain arithmetic.
module tb_fft_stage_sequencer;

    typedef struct {
        logic [31:0] busy, done, stage, rd, ra, rb, tw, ce, wr, wa, wb;
    } io_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Small instance: N=8, BF_LATENCY=2.
    logic       start8, abort8, busy8, done8, rd8, ce8, wr8;
    logic [1:0] stage8, tw8;
    logic [2:0] ra8, rb8, wa8, wb8;

    // Large instance: N=1024, BF_LATENCY=4.
    logic       start1k, abort1k, busy1k, done1k, rd1k, ce1k, wr1k;
    logic [3:0] stage1k;
    logic [8:0] tw1k;
    logic [9:0] ra1k, rb1k, wa1k, wb1k;

    fft_stage_sequencer #(.N(8), .BF_LATENCY(2)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .abort_i(abort8),
        .busy_o(busy8), .done_o(done8), .stage_o(stage8), .rd_en_o(rd8),
        .rd_addr_a_o(ra8), .rd_addr_b_o(rb8), .twiddle_addr_o(tw8),
        .bf_ce_o(ce8), .wr_en_o(wr8), .wr_addr_a_o(wa8), .wr_addr_b_o(wb8)
    );

    fft_stage_sequencer #(.N(1024), .BF_LATENCY(4)) u_dut1k (
        .clk(clk), .rst(rst), .start_i(start1k), .abort_i(abort1k),
        .busy_o(busy1k), .done_o(done1k), .stage_o(stage1k), .rd_en_o(rd1k),
        .rd_addr_a_o(ra1k), .rd_addr_b_o(rb1k), .twiddle_addr_o(tw1k),
        .bf_ce_o(ce1k), .wr_en_o(wr1k), .wr_addr_a_o(wa1k), .wr_addr_b_o(wb1k)
    );

    // Golden N=8 read order (stage 0, 1, 2).
    int gold_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int gold_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int gold_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    int rdq_a[$], rdq_b[$], rdq_tw[$], wrq_a[$], wrq_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // Is a butterfly read issued in cycle c (start sampled at the edge that
    // opens cycle 1)? Each stage takes n/2 read cycles plus lat drain cycles.
    function automatic bit model_rd(input int n, input int lat, input int c,
                                    output int s, output int k);
        int lg  = $clog2(n);
        int per = n / 2 + lat;
        int t   = c - 1;
        s = 0;
        k = 0;
        if (t < 0 || t >= lg * per) return 1'b0;
        s = t / per;
        k = t % per;
        return (k < n / 2);
    endfunction

    // Butterfly k of stage s pairs a and a+half, where a keeps the low s bits
    // of k and moves the rest up by one place.
    function automatic void model_pair(input int n, input int s, input int k,
                                       output int a, output int b, output int tw);
        int half = 1 << s;
        int pos  = k % half;
        a  = (k / half) * (2 * half) + pos;
        b  = a + half;
        tw = pos * (n / (2 * half));
    endfunction

    function automatic io_t model(input int n, input int lat, input int c);
        io_t e = '{default: '0};
        int  s, k, a, b, tw;
        int  done_c = 1 + $clog2(n) * (n / 2 + lat);
        if (c >= 1 && c <= done_c) e.busy = 1;
        if (c == done_c) e.done = 1;
        if (model_rd(n, lat, c, s, k)) begin
            model_pair(n, s, k, a, b, tw);
            e.rd = 1; e.stage = s; e.ra = a; e.rb = b; e.tw = tw; e.ce = 1;
        end
        if (model_rd(n, lat, c - lat, s, k)) begin
            model_pair(n, s, k, a, b, tw);
            e.wr = 1; e.wa = a; e.wb = b;
        end
        for (int j = 1; j <= lat; j++)
            if (model_rd(n, lat, c - j, s, k)) e.ce = 1;
        return e;
    endfunction

    function automatic io_t obs8();
        io_t o;
        o.busy = 32'(busy8); o.done = 32'(done8); o.stage = 32'(stage8);
        o.rd = 32'(rd8); o.ra = 32'(ra8); o.rb = 32'(rb8); o.tw = 32'(tw8);
        o.ce = 32'(ce8); o.wr = 32'(wr8); o.wa = 32'(wa8); o.wb = 32'(wb8);
        return o;
    endfunction

    function automatic io_t obs1k();
        io_t o;
        o.busy = 32'(busy1k); o.done = 32'(done1k); o.stage = 32'(stage1k);
        o.rd = 32'(rd1k); o.ra = 32'(ra1k); o.rb = 32'(rb1k); o.tw = 32'(tw1k);
        o.ce = 32'(ce1k); o.wr = 32'(wr1k); o.wa = 32'(wa1k); o.wb = 32'(wb1k);
        return o;
    endfunction

    task automatic compare(input string pre, input io_t o, input io_t e);
        check({pre, "busy"},  o.busy,  e.busy);
        check({pre, "done"},  o.done,  e.done);
        check({pre, "stage"}, o.stage, e.stage);
        check({pre, "rd_en"}, o.rd,    e.rd);
        check({pre, "rd_a"},  o.ra,    e.ra);
        check({pre, "rd_b"},  o.rb,    e.rb);
        check({pre, "tw"},    o.tw,    e.tw);
        check({pre, "bf_ce"}, o.ce,    e.ce);
        check({pre, "wr_en"}, o.wr,    e.wr);
        check({pre, "wr_a"},  o.wa,    e.wa);
        check({pre, "wr_b"},  o.wb,    e.wb);
    endtask

    // Idle cycles on the small instance, each checked to be all-zero.
    task automatic idle8(input int ncyc);
        io_t z = '{default: '0};
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            compare($sformatf("n8 idle%0d ", i), obs8(), z);
        end
    endtask

    // One N=8 run: start pulse in cycle 0 (called at a falling edge), optional
    // abort in cycle abort_at (<0 = none), optional random start noise while busy.
    task automatic run8(input int abort_at, input bit noise, input bit golden);
        int  done_c    = 19;
        int  done_seen = 0;
        int  done_cyc  = -1;
        io_t e;
        io_t z = '{default: '0};
        rdq_a.delete(); rdq_b.delete(); rdq_tw.delete();
        wrq_a.delete(); wrq_b.delete();
        start8 = 1'b1;
        for (int c = 1; c <= done_c + 3; c++) begin
            @(negedge clk);
            if (abort_at >= 0 && c > abort_at) e = z;
            else e = model(8, 2, c);
            compare($sformatf("n8 c%0d ", c), obs8(), e);
            if (rd8 === 1'b1) begin
                rdq_a.push_back(int'(ra8)); rdq_b.push_back(int'(rb8));
                rdq_tw.push_back(int'(tw8));
            end
            if (wr8 === 1'b1) begin
                wrq_a.push_back(int'(wa8)); wrq_b.push_back(int'(wb8));
            end
            if (done8 === 1'b1) begin
                done_seen++;
                done_cyc = c;
            end
            abort8 = (c == abort_at);
            start8 = (noise && c < done_c && (abort_at < 0 || c < abort_at))
                     ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        abort8 = 1'b0;
        start8 = 1'b0;
        if (abort_at < 0) begin
            check("n8 done_count", 32'(done_seen), 32'd1);
            check("n8 done_cycle", 32'(done_cyc), 32'(done_c));
        end else begin
            check("n8 abort_no_done", 32'(done_seen), 32'd0);
        end
        if (golden) begin
            check("n8 rd_count", 32'(rdq_a.size()), 32'd12);
            check("n8 wr_count", 32'(wrq_a.size()), 32'd12);
            for (int i = 0; i < 12 && i < rdq_a.size(); i++) begin
                check($sformatf("n8 gold_rd_a%0d", i), 32'(rdq_a[i]), 32'(gold_a[i]));
                check($sformatf("n8 gold_rd_b%0d", i), 32'(rdq_b[i]), 32'(gold_b[i]));
                check($sformatf("n8 gold_tw%0d", i), 32'(rdq_tw[i]), 32'(gold_tw[i]));
            end
            for (int i = 0; i < 12 && i < wrq_a.size(); i++) begin
                check($sformatf("n8 gold_wr_a%0d", i), 32'(wrq_a[i]), 32'(gold_a[i]));
                check($sformatf("n8 gold_wr_b%0d", i), 32'(wrq_b[i]), 32'(gold_b[i]));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        io_t z = '{default: '0};
        io_t e;
        int  abort_at;
        int  done_cyc;
        int  done_cnt;
        int  max_stage;

        rst = 1'b1;
        start8 = 1'b0; abort8 = 1'b0; start1k = 1'b0; abort1k = 1'b0;
        repeat (3) @(negedge clk);
        compare("rst8 ", obs8(), z);
        compare("rst1k ", obs1k(), z);
        rst = 1'b0;
        @(negedge clk);
        compare("post_rst8 ", obs8(), z);
        compare("post_rst1k ", obs1k(), z);

        // Golden run with random start_i noise while busy.
        run8(-1, 1'b1, 1'b1);
        idle8(int'($urandom_range(0, 4)));

        // start and abort together while idle: abort wins.
        start8 = 1'b1; abort8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; abort8 = 1'b0;
        check("n8 start_abort_busy", 32'(busy8), 32'd0);
        check("n8 start_abort_rd", 32'(rd8), 32'd0);
        idle8(2);

        // Abort in cycle 5, then a clean golden run.
        run8(5, 1'b0, 1'b0);
        run8(-1, 1'b0, 1'b1);

        // Randomised gaps, aborts and start noise.
        for (int it = 0; it < 4; it++) begin
            idle8(int'($urandom_range(0, 5)));
            abort_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 18)) : -1;
            run8(abort_at, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of stage 1.
        start8 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            compare($sformatf("n8 pre_arst c%0d ", c), obs8(), model(8, 2, c));
        end
        #2 rst = 1'b1;
        #1 compare("n8 arst_immediate ", obs8(), z);
        @(negedge clk);
        compare("n8 arst_held ", obs8(), z);
        rst = 1'b0;
        idle8(1);
        run8(-1, 1'b0, 1'b1);

        // Full-size run with an extra start pulse in cycle 100.
        done_cyc = -1; done_cnt = 0; max_stage = 0;
        start1k = 1'b1;
        for (int c = 1; c <= 5165; c++) begin
            @(negedge clk);
            e = model(1024, 4, c);
            compare($sformatf("n1k c%0d ", c), obs1k(), e);
            if (done1k === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (rd1k === 1'b1 && int'(stage1k) > max_stage) max_stage = int'(stage1k);
            start1k = (c == 100);
        end
        start1k = 1'b0;
        check("n1k done_count", 32'(done_cnt), 32'd1);
        check("n1k done_cycle", 32'(done_cyc), 32'd5161);
        check("n1k max_stage", 32'(max_stage), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
